rggen_register_bus_arbiter: RTL and testbench

//  Shares one register-bus slave port (the register block's valid/access/address/write_data/strobe ->

---
 rtl/rggen_register_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_rggen_register_bus_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_register_bus_arbiter.sv
// Round-robin arbiter sharing one register-bus slave port between HOSTS bus hosts.
// The grant is held for a full IDLE -> BUSY -> RESP transaction; all outputs are registered.
module rggen_register_bus_arbiter #(
   parameter int HOSTS         = 2,
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic [HOSTS-1:0]                 i_host_valid,
   input  logic [2*HOSTS-1:0]               i_host_access,
   input  logic [ADDRESS_WIDTH*HOSTS-1:0]   i_host_address,
   input  logic [BUS_WIDTH*HOSTS-1:0]       i_host_write_data,
   input  logic [BUS_WIDTH/8*HOSTS-1:0]     i_host_strobe,
   output logic [HOSTS-1:0]                 o_host_ready,
   output logic [2*HOSTS-1:0]               o_host_status,
   output logic [BUS_WIDTH*HOSTS-1:0]       o_host_read_data,
   output logic [HOSTS-1:0]                 o_grant,
   output logic                             o_register_valid,
   output logic [1:0]                       o_register_access,
   output logic [ADDRESS_WIDTH-1:0]         o_register_address,
   output logic [BUS_WIDTH-1:0]             o_register_write_data,
   output logic [BUS_WIDTH/8-1:0]           o_register_strobe,
   input  logic                             i_register_ready,
   input  logic [1:0]                       i_register_status,
   input  logic [BUS_WIDTH-1:0]             i_register_read_data
);
   localparam int SW = BUS_WIDTH / 8;
   localparam int PW = (HOSTS > 1) ? $clog2(HOSTS) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

   state_t                     r_state, w_state_next;
   logic [PW-1:0]              r_last, w_last_next;
   logic [PW-1:0]              r_idx, w_idx_next;
   logic [PW-1:0]              w_sel, w_cand;
   logic                       w_found;
   logic [HOSTS-1:0]           r_grant, w_grant_next;
   logic                       r_reg_valid, w_reg_valid_next;
   logic [1:0]                 r_reg_access, w_reg_access_next;
   logic [ADDRESS_WIDTH-1:0]   r_reg_address, w_reg_address_next;
   logic [BUS_WIDTH-1:0]       r_reg_wdata, w_reg_wdata_next;
   logic [SW-1:0]              r_reg_strobe, w_reg_strobe_next;
   logic [HOSTS-1:0]           r_host_ready, w_host_ready_next;
   logic [2*HOSTS-1:0]         r_host_status, w_host_status_next;
   logic [BUS_WIDTH*HOSTS-1:0] r_host_rdata, w_host_rdata_next;

   // First valid host searching upward from last+1 with wrap-around.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_cand  = '0;
      for (int i = 1; i <= HOSTS; i++) begin
         w_cand = PW'((int'(r_last) + i) % HOSTS);
         if (!w_found && i_host_valid[w_cand]) begin
            w_found = 1'b1;
            w_sel   = w_cand;
         end
      end
   end

   always_comb begin
      w_state_next       = r_state;
      w_last_next        = r_last;
      w_idx_next         = r_idx;
      w_grant_next       = r_grant;
      w_reg_valid_next   = r_reg_valid;
      w_reg_access_next  = r_reg_access;
      w_reg_address_next = r_reg_address;
      w_reg_wdata_next   = r_reg_wdata;
      w_reg_strobe_next  = r_reg_strobe;
      w_host_ready_next  = '0;
      w_host_status_next = '0;
      w_host_rdata_next  = '0;
      unique case (r_state)
         StIdle: begin
            w_grant_next = '0;
            if (w_found) begin
               w_state_next          = StBusy;
               w_last_next           = w_sel;
               w_idx_next            = w_sel;
               w_grant_next[w_sel]   = 1'b1;
               w_reg_valid_next      = 1'b1;
               w_reg_access_next     = i_host_access[2*w_sel+:2];
               w_reg_address_next    = i_host_address[ADDRESS_WIDTH*w_sel+:ADDRESS_WIDTH];
               w_reg_wdata_next      = i_host_write_data[BUS_WIDTH*w_sel+:BUS_WIDTH];
               w_reg_strobe_next     = i_host_strobe[SW*w_sel+:SW];
            end
         end
         StBusy: begin
            // Host inputs are ignored here; only the slave can end the transaction.
            if (i_register_ready) begin
               w_state_next                                = StResp;
               w_reg_valid_next                            = 1'b0;
               w_host_ready_next[r_idx]                    = 1'b1;
               w_host_status_next[2*r_idx+:2]              = i_register_status;
               w_host_rdata_next[BUS_WIDTH*r_idx+:BUS_WIDTH] = i_register_read_data;
            end
         end
         StResp: begin
            w_state_next = StIdle;
            w_grant_next = '0;
         end
         default: begin
            w_state_next     = StIdle;
            w_grant_next     = '0;
            w_reg_valid_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= StIdle;
         r_last        <= PW'(HOSTS - 1);
         r_idx         <= '0;
         r_grant       <= '0;
         r_reg_valid   <= 1'b0;
         r_reg_access  <= '0;
         r_reg_address <= '0;
         r_reg_wdata   <= '0;
         r_reg_strobe  <= '0;
         r_host_ready  <= '0;
         r_host_status <= '0;
         r_host_rdata  <= '0;
      end else begin
         r_state       <= w_state_next;
         r_last        <= w_last_next;
         r_idx         <= w_idx_next;
         r_grant       <= w_grant_next;
         r_reg_valid   <= w_reg_valid_next;
         r_reg_access  <= w_reg_access_next;
         r_reg_address <= w_reg_address_next;
         r_reg_wdata   <= w_reg_wdata_next;
         r_reg_strobe  <= w_reg_strobe_next;
         r_host_ready  <= w_host_ready_next;
         r_host_status <= w_host_status_next;
         r_host_rdata  <= w_host_rdata_next;
      end
   end

   assign o_host_ready          = r_host_ready;
   assign o_host_status         = r_host_status;
   assign o_host_read_data      = r_host_rdata;
   assign o_grant               = r_grant;
   assign o_register_valid      = r_reg_valid;
   assign o_register_access     = r_reg_access;
   assign o_register_address    = r_reg_address;
   assign o_register_write_data = r_reg_wdata;
   assign o_register_strobe     = r_reg_strobe;

endmodule

// File: tb/tb_rggen_register_bus_arbiter.sv
// Directed bench for rggen_register_bus_arbiter with four hosts: vector table for
// single transactions plus hand-written reset, round-robin, stall and reset-in-busy sequences.
module tb_rggen_register_bus_arbiter;
   localparam int H  = 4;
   localparam int AW = 8;
   localparam int BW = 32;

   logic              clk;
   logic              rst;
   logic [H-1:0]      host_valid;
   logic [2*H-1:0]    host_access;
   logic [AW*H-1:0]   host_address;
   logic [BW*H-1:0]   host_wdata;
   logic [BW/8*H-1:0] host_strobe;
   logic [H-1:0]      host_ready;
   logic [2*H-1:0]    host_status;
   logic [BW*H-1:0]   host_rdata;
   logic [H-1:0]      grant;
   logic              reg_valid;
   logic [1:0]        reg_access;
   logic [AW-1:0]     reg_address;
   logic [BW-1:0]     reg_wdata;
   logic [BW/8-1:0]   reg_strobe;
   logic              reg_ready;
   logic [1:0]        reg_status;
   logic [BW-1:0]     reg_rdata;

   int n_chk = 0;
   int n_err = 0;

   rggen_register_bus_arbiter #(
      .HOSTS         (H),
      .ADDRESS_WIDTH (AW),
      .BUS_WIDTH     (BW)
   ) dut (
      .i_clk                 (clk),
      .i_rst                 (rst),
      .i_host_valid          (host_valid),
      .i_host_access         (host_access),
      .i_host_address        (host_address),
      .i_host_write_data     (host_wdata),
      .i_host_strobe         (host_strobe),
      .o_host_ready          (host_ready),
      .o_host_status         (host_status),
      .o_host_read_data      (host_rdata),
      .o_grant               (grant),
      .o_register_valid      (reg_valid),
      .o_register_access     (reg_access),
      .o_register_address    (reg_address),
      .o_register_write_data (reg_wdata),
      .o_register_strobe     (reg_strobe),
      .i_register_ready      (reg_ready),
      .i_register_status     (reg_status),
      .i_register_read_data  (reg_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [H-1:0]    valid;
      logic            rdy;
      logic [1:0]      st;
      logic [BW-1:0]   rd;
      logic [H-1:0]    e_grant;
      logic            e_rvalid;
      logic [AW-1:0]   e_addr;
      logic [H-1:0]    e_hready;
      logic [2*H-1:0]  e_hstatus;
      logic [BW*H-1:0] e_hrdata;
   } vec_t;

   vec_t vecs[7];
   int   order[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_host(input int h, input logic [1:0] a, input logic [AW-1:0] ad,
                           input logic [BW-1:0] wd, input logic [3:0] s);
      host_access[2*h+:2]    = a;
      host_address[AW*h+:AW] = ad;
      host_wdata[BW*h+:BW]   = wd;
      host_strobe[4*h+:4]    = s;
   endtask

   initial begin
      int pulses;
      // Single read to host1, then error status to host2 (with one stall cycle).
      vecs[0] = '{4'b0010, 1'b0, 2'b00, 32'h0, 4'b0010, 1'b1, 8'h10, 4'b0000, 8'h00, 128'h0};
      vecs[1] = '{4'b0010, 1'b1, 2'b00, 32'hDEADBEEF, 4'b0010, 1'b0, 8'h00, 4'b0010, 8'h00,
                  {64'h0, 32'hDEADBEEF, 32'h0}};
      vecs[2] = '{4'b0000, 1'b0, 2'b00, 32'h0, 4'b0000, 1'b0, 8'h00, 4'b0000, 8'h00, 128'h0};
      vecs[3] = '{4'b0100, 1'b0, 2'b00, 32'h0, 4'b0100, 1'b1, 8'h24, 4'b0000, 8'h00, 128'h0};
      vecs[4] = '{4'b0100, 1'b0, 2'b00, 32'h0, 4'b0100, 1'b1, 8'h24, 4'b0000, 8'h00, 128'h0};
      vecs[5] = '{4'b0100, 1'b1, 2'b10, 32'h12345678, 4'b0100, 1'b0, 8'h00, 4'b0100, 8'h20,
                  {32'h0, 32'h12345678, 64'h0}};
      vecs[6] = '{4'b0000, 1'b0, 2'b00, 32'h0, 4'b0000, 1'b0, 8'h00, 4'b0000, 8'h00, 128'h0};
      order   = '{0, 1, 2, 3, 0, 1};

      rst = 1'b1; host_valid = '0; host_access = '0; host_address = '0;
      host_wdata = '0; host_strobe = '0; reg_ready = 1'b0; reg_status = '0; reg_rdata = '0;
      set_host(0, 2'b00, 8'h04, 32'h0, 4'hF);
      set_host(1, 2'b00, 8'h10, 32'h0, 4'hF);
      set_host(2, 2'b01, 8'h24, 32'h22222222, 4'h3);
      set_host(3, 2'b01, 8'h38, 32'h33333333, 4'hC);

      // Reset held two cycles with hosts 0 and 1 requesting.
      host_valid = 4'b0011;
      tick();
      tick();
      chk("rst grant", 128'(grant), 128'h0);
      chk("rst reg_valid", 128'(reg_valid), 128'h0);
      chk("rst host_ready", 128'(host_ready), 128'h0);
      chk("rst host_status", 128'(host_status), 128'h0);
      chk("rst host_rdata", host_rdata, 128'h0);
      chk("rst reg_payload", {reg_access, reg_address, reg_wdata, reg_strobe}, 128'h0);
      rst = 1'b0;
      tick();
      chk("rel grant", 128'(grant), 128'h1);
      chk("rel reg_valid", 128'(reg_valid), 128'h1);
      chk("rel address", 128'(reg_address), 128'h04);
      reg_ready = 1'b1; reg_rdata = 32'hCAFEF00D;
      tick();
      chk("rel host_ready", 128'(host_ready), 128'h1);
      chk("rel host_rdata", host_rdata, 128'hCAFEF00D);
      reg_ready = 1'b0; reg_rdata = '0; host_valid = '0;
      tick();
      chk("rel idle grant", 128'(grant), 128'h0);

      for (int i = 0; i < 7; i++) begin
         host_valid = vecs[i].valid;
         reg_ready  = vecs[i].rdy;
         reg_status = vecs[i].st;
         reg_rdata  = vecs[i].rd;
         tick();
         chk($sformatf("vec%0d grant", i), 128'(grant), 128'(vecs[i].e_grant));
         chk($sformatf("vec%0d reg_valid", i), 128'(reg_valid), 128'(vecs[i].e_rvalid));
         chk($sformatf("vec%0d host_ready", i), 128'(host_ready), 128'(vecs[i].e_hready));
         chk($sformatf("vec%0d host_status", i), 128'(host_status), 128'(vecs[i].e_hstatus));
         chk($sformatf("vec%0d host_rdata", i), host_rdata, vecs[i].e_hrdata);
         if (vecs[i].e_rvalid)
            chk($sformatf("vec%0d address", i), 128'(reg_address), 128'(vecs[i].e_addr));
      end
      reg_ready = 1'b0; reg_status = '0; reg_rdata = '0;

      // Round-robin with all hosts valid and slave always ready.
      rst = 1'b1;
      tick();
      rst = 1'b0; host_valid = 4'b1111; reg_ready = 1'b1; reg_rdata = 32'h5A5A0000;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("rr%0d grant", k), 128'(grant), 128'(4'b0001 << order[k]));
         chk($sformatf("rr%0d reg_valid", k), 128'(reg_valid), 128'h1);
         chk($sformatf("rr%0d address", k), 128'(reg_address),
             128'(host_address[AW*order[k]+:AW]));
         tick();
         chk($sformatf("rr%0d host_ready", k), 128'(host_ready), 128'(4'b0001 << order[k]));
         tick();
         chk($sformatf("rr%0d idle grant", k), 128'(grant), 128'h0);
      end
      host_valid = '0; reg_ready = 1'b0;

      // Slave stall of five cycles while host0 alters its payload.
      set_host(0, 2'b01, 8'h55, 32'hA5A5A5A5, 4'hF);
      host_valid = 4'b0001;
      tick();
      chk("stall grant", 128'(grant), 128'h1);
      set_host(0, 2'b10, 8'hAA, 32'h0, 4'h0);
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         pulses += $countones(host_ready);
         chk($sformatf("stall%0d hold", c), {reg_valid, reg_access, reg_address, reg_wdata,
             reg_strobe}, {1'b1, 2'b01, 8'h55, 32'hA5A5A5A5, 4'hF});
      end
      reg_ready = 1'b1; reg_rdata = 32'h0BADF00D;
      tick();
      pulses += $countones(host_ready);
      chk("stall host_ready", 128'(host_ready), 128'h1);
      chk("stall host_rdata", host_rdata, 128'h0BADF00D);
      reg_ready = 1'b0; reg_rdata = '0; host_valid = '0;
      tick();
      pulses += $countones(host_ready);
      tick();
      pulses += $countones(host_ready);
      chk("stall pulse count", 128'(pulses), 128'd1);

      // Reset while waiting on the slave.
      host_valid = 4'b0011;
      tick();
      chk("rb grant", 128'(grant), 128'h2);
      tick();
      chk("rb busy reg_valid", 128'(reg_valid), 128'h1);
      rst = 1'b1; reg_ready = 1'b1;
      tick();
      chk("rb reg_valid", 128'(reg_valid), 128'h0);
      chk("rb host_ready", 128'(host_ready), 128'h0);
      chk("rb grant cleared", 128'(grant), 128'h0);
      rst = 1'b0; reg_ready = 1'b0;
      tick();
      chk("rb host_ready after", 128'(host_ready), 128'h0);
      chk("rb host0 priority", 128'(grant), 128'h1);
      reg_ready = 1'b1;
      tick();
      chk("rb host0 served", 128'(host_ready), 128'h1);
      reg_ready = 1'b0; host_valid = '0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
